pwm_config_scheduler: RTL and testbench
=======================================

// Module: pwm_config_scheduler
// PURPOSE
//  Arbitrates register-write requests from two requesters (A: SPI peripheral, B: on-chip
//  sequencer/debug) onto the 5-entry PWM/output configuration bank. Holds writes in shadow
//  registers and commits them to the active bank either immediately or on a PWM period
//  boundary, so the duty cycle never changes mid-period. Owns the PWM period timebase.
// PARAMETERS
//  CLK_DIV   13   clk cycles per PWM count step (>=1); period = 256*CLK_DIV clk cycles
//  N_REGS    5    implemented addresses 0..N_REGS-1; fixed map below
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous active-low reset
//  a_req            in   1  requester A write request; held until a_ack
//  a_addr           in   7  requester A register address
//  a_data           in   8  requester A write data
//  a_ack            out  1  one-cycle acknowledge to A
//  b_req/b_addr/b_data/b_ack    same as A, for requester B
//  commit_mode      in   1  0 = commit immediately, 1 = commit at period_start
//  en_reg_out_7_0   out  8  active bank addr 0x00
//  en_reg_out_15_8  out  8  active bank addr 0x01
//  en_reg_pwm_7_0   out  8  active bank addr 0x02
//  en_reg_pwm_15_8  out  8  active bank addr 0x03
//  pwm_duty_cycle   out  8  active bank addr 0x04
//  pwm_count        out  8  PWM period counter 0..255
//  period_start     out  1  high for the single clk where div_cnt==0 && pwm_count==0
//  pending          out  1  shadow holds uncommitted data
//  addr_err         out  1  one-cycle pulse: acked write to address >= N_REGS
// BEHAVIOUR
//  - Reset (async, rst_n=0): active+shadow banks 0x00, acks 0, pending 0, addr_err 0,
//    pwm_count 0, div_cnt 0, FSM IDLE, RR pointer favours A. In-flight request dropped,
//    no ack issued. period_start is high in the first cycle after reset release.
//  - FSM: IDLE -> GRANT_A | GRANT_B -> IDLE. Every write takes exactly 2 cycles.
//    IDLE: sample reqs at the clock edge. Only one high -> grant it. Both high -> grant the
//    requester not granted last (RR). Neither -> stay IDLE.
//    GRANT_x: x_ack=1 for this cycle only; at the end of this cycle, shadow[addr] <= data
//    (addr < N_REGS), else addr_err pulses in the same cycle as the ack and nothing is
//    written. Always -> IDLE. Acks are never asserted simultaneously.
//  - Requester protocol: keep req/addr/data stable until ack; drop req on the edge ending
//    the ack cycle. A req still high in IDLE is treated as a new request.
//  - Commit, commit_mode=0: the active register updates on the same edge as the shadow
//    write; new value visible the cycle after ack; pending stays 0.
//  - Commit, commit_mode=1: a shadow write sets pending. On any edge where period_start=1
//    and pending=1 (or a write lands on that same edge), active <= shadow incl. that write;
//    pending clears. Multiple writes within a period: last write per address wins.
//  - commit_mode 1->0 with pending=1: whole shadow committed on the next edge; pending clears.
//  - Timebase: div_cnt counts 0..CLK_DIV-1 and wraps. pwm_count increments when div_cnt
//    wraps, 255 wraps to 0. Free-running, unaffected by writes or commit mode.
//  - Widths: all counters unsigned; no saturation; div_cnt sized by $clog2(CLK_DIV) (min 1).
// TESTING
//  1 Reset: rst_n=0 mid GRANT_A -> a_ack never seen, all outputs 0, FSM IDLE after release.
//  2 mode=0, A writes 0x04<=0x80 -> a_ack 1 cycle after req; pwm_duty_cycle=0x80 next cycle.
//  3 A and B req same cycle, 3 writes each -> grants A,B,A,B,A,B; acks never overlap.
//  4 mode=1, write 0x04<=0x40 at pwm_count=10 -> pending=1, duty unchanged until
//    period_start, then 0x40 and pending=0; write landing on the period_start edge commits.
//  5 A writes addr 0x05 data 0xFF -> a_ack and addr_err same cycle, active bank unchanged.
//  6 CLK_DIV=13 -> period_start exactly every 3328 clk; pwm_count wraps 255->0.

Source files
------------

// File: rtl/pwm_config_scheduler.sv
// Two-requester write arbiter in front of a 5-entry PWM/output configuration bank.
// Writes land in a shadow bank and reach the active bank immediately or at the next period start.
module pwm_config_scheduler #(
    parameter int CLK_DIV = 13,
    parameter int N_REGS  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_ack,
    input  logic       commit_mode,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic [7:0] pwm_count,
    output logic       period_start,
    output logic       pending,
    output logic       addr_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]       ADDR_LIM = 7'(N_REGS);

    state_t           state_q, state_d;
    logic             last_a_q, last_a_d;
    logic             a_ack_q, b_ack_q, addr_err_q, addr_err_d;
    logic             pending_q, pending_d;
    logic             grant_a_s, grant_b_s;
    logic             wr_en_s;
    logic [6:0]       wr_addr_s;
    logic [7:0]       wr_data_s;
    logic             period_start_s;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       pwm_count_q, pwm_count_d;
    logic [7:0]       shadow_q [N_REGS];
    logic [7:0]       shadow_d [N_REGS];
    logic [7:0]       active_q [N_REGS];
    logic [7:0]       active_d [N_REGS];

    // Arbitration: round-robin on contention, favouring whoever was not granted last
    always_comb begin
        state_d   = IDLE;
        last_a_d  = last_a_q;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req && b_req) begin
                    if (last_a_q) begin
                        grant_b_s = 1'b1;
                    end else begin
                        grant_a_s = 1'b1;
                    end
                end else if (a_req) begin
                    grant_a_s = 1'b1;
                end else if (b_req) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b0;
                end
                if (grant_a_s) begin
                    state_d  = GRANT_A;
                    last_a_d = 1'b1;
                end else if (grant_b_s) begin
                    state_d  = GRANT_B;
                    last_a_d = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            GRANT_A, GRANT_B: state_d = IDLE;
            default:          state_d = IDLE;
        endcase
        addr_err_d = (grant_a_s && (a_addr >= ADDR_LIM)) || (grant_b_s && (b_addr >= ADDR_LIM));
    end

    // Write port of the granted requester; its address/data are held stable until the ack ends
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 7'd0;
        wr_data_s = 8'd0;
        case (state_q)
            GRANT_A: begin
                wr_addr_s = a_addr;
                wr_data_s = a_data;
                wr_en_s   = (a_addr < ADDR_LIM);
            end
            GRANT_B: begin
                wr_addr_s = b_addr;
                wr_data_s = b_data;
                wr_en_s   = (b_addr < ADDR_LIM);
            end
            default: wr_en_s = 1'b0;
        endcase
    end

    // Free-running period timebase
    always_comb begin
        period_start_s = (div_cnt_q == {DIV_W{1'b0}}) && (pwm_count_q == 8'd0);
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d   = {DIV_W{1'b0}};
            pwm_count_d = pwm_count_q + 8'd1;
        end else begin
            div_cnt_d   = div_cnt_q + DIV_W'(1);
            pwm_count_d = pwm_count_q;
        end
    end

    // Shadow update and commit; while nothing is pending the shadow equals the active bank
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        for (int i = 0; i < N_REGS; i++) begin
            if (wr_en_s && (wr_addr_s == 7'(i))) begin
                shadow_d[i] = wr_data_s;
            end else begin
                shadow_d[i] = shadow_q[i];
            end
        end
        if (!commit_mode) begin
            active_d  = shadow_d;
            pending_d = 1'b0;
        end else if (period_start_s && (pending_q || wr_en_s)) begin
            active_d  = shadow_d;
            pending_d = 1'b0;
        end else if (wr_en_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // State, bank and timebase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_a_q    <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            addr_err_q  <= 1'b0;
            pending_q   <= 1'b0;
            div_cnt_q   <= {DIV_W{1'b0}};
            pwm_count_q <= 8'd0;
            for (int i = 0; i < N_REGS; i++) begin
                shadow_q[i] <= 8'd0;
                active_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            last_a_q    <= last_a_d;
            a_ack_q     <= grant_a_s;
            b_ack_q     <= grant_b_s;
            addr_err_q  <= addr_err_d;
            pending_q   <= pending_d;
            div_cnt_q   <= div_cnt_d;
            pwm_count_q <= pwm_count_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    assign a_ack           = a_ack_q;
    assign b_ack           = b_ack_q;
    assign addr_err        = addr_err_q;
    assign pending         = pending_q;
    assign pwm_count       = pwm_count_q;
    assign period_start    = period_start_s;
    assign en_reg_out_7_0  = active_q[0];
    assign en_reg_out_15_8 = active_q[1];
    assign en_reg_pwm_7_0  = active_q[2];
    assign en_reg_pwm_15_8 = active_q[3];
    assign pwm_duty_cycle  = active_q[4];

endmodule

// File: tb/tb_pwm_config_scheduler.sv
// Randomized self-checking bench for pwm_config_scheduler against a behavioural model
// built from elapsed-cycle arithmetic and plain shadow/active arrays.
module tb_pwm_config_scheduler;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic       clk;
    logic       rst_n;
    logic       a_req, b_req, a_ack, b_ack;
    logic [6:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       commit_mode;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle, pwm_count;
    logic       period_start, pending, addr_err;

    int         checks = 0;
    int         errors = 0;
    int         cyc;
    logic [7:0] m_shadow [5];
    logic [7:0] m_active [5];
    bit         m_pend;
    bit         last_b;
    bit         wr_v;
    int         wr_a;
    logic [7:0] wr_d;

    pwm_config_scheduler #(.CLK_DIV(CLK_DIV), .N_REGS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
        .commit_mode(commit_mode),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .pwm_count(pwm_count),
        .period_start(period_start), .pending(pending), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            4:       return pwm_duty_cycle;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_pend = 1'b0;
        last_b = 1'b1;
        wr_v   = 1'b0;
        cyc    = 0;
    endtask

    // One clock: model applies the write landing on this edge and any commit due, returns at negedge
    task automatic tick();
        bit ps;
        bit m;
        ps = ((cyc % PERIOD) == 0);
        m  = commit_mode;
        @(posedge clk);
        if (wr_v && wr_a < 5) begin
            m_shadow[wr_a] = wr_d;
            if (m) m_pend = 1'b1;
        end
        if (!m) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end else if (ps && m_pend) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end
        wr_v = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    // Single-requester write: ack expected in the cycle after the request, write lands at its end
    task automatic do_write(input bit who_b, input logic [6:0] addr, input logic [7:0] data);
        bit exp_err;
        exp_err = (addr >= 7'd5);
        if (who_b) begin
            b_req = 1'b1; b_addr = addr; b_data = data;
        end else begin
            a_req = 1'b1; a_addr = addr; a_data = data;
        end
        tick();
        checks++;
        if ({a_ack, b_ack} !== (who_b ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL write_ack: a_ack,b_ack=%b%b required %b", a_ack, b_ack, (who_b ? 2'b01 : 2'b10));
        end
        checks++;
        if (addr_err !== exp_err) begin
            errors++;
            $display("FAIL write_addr_err addr=%0h: got %b required %b", addr, addr_err, exp_err);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        wr_v = 1'b1; wr_a = int'(addr); wr_d = data;
        last_b = who_b;
        tick();
        checks++;
        if ({a_ack, b_ack, addr_err} !== 3'b000) begin
            errors++;
            $display("FAIL write_ack_len: a_ack,b_ack,addr_err=%b%b%b required 000", a_ack, b_ack, addr_err);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== m_active[i]) begin
                errors++;
                $display("FAIL write_bank[%0d]: got %0h required %0h", i, dut_reg(i), m_active[i]);
            end
        end
        checks++;
        if (pending !== m_pend) begin
            errors++;
            $display("FAIL write_pending: got %b required %b", pending, m_pend);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; commit_mode = 1'b0;
        a_addr = 7'd0; b_addr = 7'd0; a_data = 8'd0; b_data = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        a_req = 1'b1; a_addr = 7'd4; a_data = 8'h77;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ack, b_ack, addr_err, pending} !== 4'b0000 || pwm_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: ack/err/pend=%b%b%b%b pwm=%0d required 0", a_ack, b_ack, addr_err, pending, pwm_count);
        end
        a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== 8'h00) begin
                errors++;
                $display("FAIL reset_bank[%0d]: got %0h required 00", i, dut_reg(i));
            end
        end
        checks++;
        if (period_start !== 1'b1 || pwm_count !== 8'd0 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: period_start=%b pwm=%0d a_ack=%b required 1,0,0", period_start, pwm_count, a_ack);
        end
    endtask

    task automatic test_mode0();
        commit_mode = 1'b0;
        do_write(1'b0, 7'h04, 8'h80);
        checks++;
        if (pwm_duty_cycle !== 8'h80 || pending !== 1'b0) begin
            errors++;
            $display("FAIL mode0_duty: got %0h pend %b required 80 pend 0", pwm_duty_cycle, pending);
        end
        for (int k = 0; k < 6; k++) begin
            do_write(1'($urandom_range(0, 1)), 7'($urandom_range(0, 4)), 8'($urandom));
        end
    endtask

    task automatic test_addr_err();
        logic [7:0] snap [5];
        for (int i = 0; i < 5; i++) snap[i] = dut_reg(i);
        do_write(1'b0, 7'h05, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== snap[i]) begin
                errors++;
                $display("FAIL addr_err_bank[%0d]: got %0h required %0h", i, dut_reg(i), snap[i]);
            end
        end
        do_write(1'b1, 7'h7F, 8'h12);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ad [2][3];
        logic [7:0] dd [2][3];
        int         idx [2];
        int         n;
        bit         got_b, exp_b;
        commit_mode = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                ad[r][k] = 7'($urandom_range(0, 4));
                dd[r][k] = 8'($urandom);
            end
        end
        idx[0] = 0; idx[1] = 0; n = 0;
        a_addr = ad[0][0]; a_data = dd[0][0]; a_req = 1'b1;
        b_addr = ad[1][0]; b_data = dd[1][0]; b_req = 1'b1;
        for (int c = 0; c < 30 && (idx[0] < 3 || idx[1] < 3); c++) begin
            tick();
            checks++;
            if (a_ack && b_ack) begin
                errors++;
                $display("FAIL b2b_overlap: a_ack=1 b_ack=1 required at most one");
            end
            if (a_ack || b_ack) begin
                got_b = !a_ack;
                exp_b = (idx[0] < 3 && idx[1] < 3) ? !last_b : (idx[0] >= 3);
                checks++;
                if (got_b !== exp_b) begin
                    errors++;
                    $display("FAIL b2b_order #%0d: granted B=%b required B=%b", n, got_b, exp_b);
                end
                if (idx[got_b] < 3) begin
                    wr_v = 1'b1; wr_a = int'(ad[got_b][idx[got_b]]); wr_d = dd[got_b][idx[got_b]];
                    idx[got_b]++;
                end
                last_b = got_b;
                n++;
                if (idx[got_b] >= 3) begin
                    if (got_b) b_req = 1'b0; else a_req = 1'b0;
                end
                tick();
                checks++;
                if (a_ack || b_ack) begin
                    errors++;
                    $display("FAIL b2b_gap: a_ack,b_ack=%b%b required 00", a_ack, b_ack);
                end
                if (idx[got_b] < 3) begin
                    if (got_b) begin
                        b_addr = ad[1][idx[1]]; b_data = dd[1][idx[1]];
                    end else begin
                        a_addr = ad[0][idx[0]]; a_data = dd[0][idx[0]];
                    end
                end
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d acks required 6", n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== m_active[i]) begin
                errors++;
                $display("FAIL b2b_bank[%0d]: got %0h required %0h", i, dut_reg(i), m_active[i]);
            end
        end
    endtask

    task automatic test_commit_mode1();
        logic [7:0] old;
        commit_mode = 1'b1;
        for (int k = 0; k < PERIOD + 2 && ((cyc / CLK_DIV) % 256) != 10; k++) tick();
        old = m_active[4];
        do_write(1'b0, 7'h04, 8'h40);
        checks++;
        if (pending !== 1'b1 || pwm_duty_cycle !== old) begin
            errors++;
            $display("FAIL mode1_hold: pend=%b duty=%0h required 1,%0h", pending, pwm_duty_cycle, old);
        end
        for (int k = 0; k < PERIOD + 2 && (cyc % PERIOD) != 0; k++) begin
            tick();
            checks++;
            if (pwm_duty_cycle !== old) begin
                errors++;
                $display("FAIL mode1_early: duty=%0h required %0h at cyc %0d", pwm_duty_cycle, old, cyc);
            end
        end
        tick();
        checks++;
        if (pwm_duty_cycle !== 8'h40 || pending !== 1'b0) begin
            errors++;
            $display("FAIL mode1_commit: duty=%0h pend=%b required 40,0", pwm_duty_cycle, pending);
        end
        for (int k = 0; k < PERIOD + 2 && (cyc % PERIOD) != PERIOD - 1; k++) tick();
        do_write(1'b1, 7'h04, 8'h21);
        checks++;
        if (pwm_duty_cycle !== 8'h21 || pending !== 1'b0) begin
            errors++;
            $display("FAIL mode1_edge_write: duty=%0h pend=%b required 21,0", pwm_duty_cycle, pending);
        end
        do_write(1'b0, 7'h00, 8'h5A);
        commit_mode = 1'b0;
        tick();
        checks++;
        if (en_reg_out_7_0 !== 8'h5A || pending !== 1'b0) begin
            errors++;
            $display("FAIL mode_switch: out_7_0=%0h pend=%b required 5a,0", en_reg_out_7_0, pending);
        end
    endtask

    task automatic test_period();
        logic [7:0] prev;
        int         gap;
        for (int k = 0; k < PERIOD + 2 && (cyc % PERIOD) != 0; k++) tick();
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL period_align: period_start=%b required 1", period_start);
        end
        gap = 0;
        prev = pwm_count;
        for (int k = 0; k < PERIOD + 5; k++) begin
            prev = pwm_count;
            tick();
            gap++;
            checks++;
            if (pwm_count !== 8'((cyc / CLK_DIV) % 256) || period_start !== ((cyc % PERIOD) == 0)) begin
                errors++;
                $display("FAIL timebase cyc=%0d: pwm=%0d ps=%b required %0d,%b", cyc, pwm_count, period_start, (cyc / CLK_DIV) % 256, (cyc % PERIOD) == 0);
            end
            if (period_start === 1'b1) break;
        end
        checks++;
        if (gap != PERIOD || prev !== 8'd255 || pwm_count !== 8'd0) begin
            errors++;
            $display("FAIL period_len: gap=%0d prev=%0d now=%0d required %0d,255,0", gap, prev, pwm_count, PERIOD);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                int target;
                target = PERIOD - 1 - int'($urandom_range(0, 1));
                for (int k = 0; k < PERIOD + 2 && (cyc % PERIOD) != target; k++) tick();
            end
            commit_mode = 1'($urandom_range(0, 1));
            do_write(1'($urandom_range(0, 1)), 7'($urandom_range(0, 6)), 8'($urandom));
            repeat ($urandom_range(0, 3)) begin
                tick();
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (dut_reg(i) !== m_active[i]) begin
                        errors++;
                        $display("FAIL rand_bank[%0d] it=%0d: got %0h required %0h", i, it, dut_reg(i), m_active[i]);
                    end
                end
                checks++;
                if (pending !== m_pend || pwm_count !== 8'((cyc / CLK_DIV) % 256)) begin
                    errors++;
                    $display("FAIL rand_state it=%0d: pend=%b pwm=%0d required %b,%0d", it, pending, pwm_count, m_pend, (cyc / CLK_DIV) % 256);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_addr_err();
        test_back_to_back();
        test_commit_mode1();
        test_period();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
